// File: rtl/aline_fire_sequencer.sv
// Sequences one image acquisition: per A-line, request delays, wait for the load, fire enabled channels.
// Latency: rd_en one cycle after start; fire[c] starts D_c cycles into FIRE; outputs registered.
// Backpressure: waits on updating_delays handshake with timeout; abort/intaking_configs force IDLE.
module aline_fire_sequencer #(
    parameter int GAP_CYCLES  = 1000,
    parameter int UPD_TIMEOUT = 64,
    parameter int MAX_ALINES  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         intaking_configs,
    input  logic         updating_delays,
    input  logic [4:0]   aline_select,
    input  logic [7:0]   channel_select,
    input  logic [31:0]  pulse_shape,
    input  logic [127:0] ch_delays,
    output logic         rd_en,
    output logic [3:0]   which_aline,
    output logic [7:0]   fire,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int TW = $clog2(UPD_TIMEOUT) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_HI,
        S_WAIT_LO,
        S_ARM,
        S_FIRE,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    wa_q, wa_d;
    logic [3:0]    last_q, last_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          rd_en_q, rd_en_d;
    logic [7:0]    fire_q, fire_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // Per-channel pulse engine: countdown to the first bit, then 32 MSB-first shifts.
    logic [15:0]   dly_q [8];
    logic [15:0]   dly_d [8];
    logic [31:0]   sh_q [8];
    logic [31:0]   sh_d [8];
    logic [5:0]    left_q [8];
    logic [5:0]    left_d [8];
    logic [15:0]   dly_adv [8];
    logic [31:0]   sh_adv [8];
    logic [5:0]    left_adv [8];
    logic [7:0]    chan_idle;
    logic          fire_last;
    logic [4:0]    n_sel;

    // Image length clamped to what which_aline can index.
    assign n_sel = (aline_select > 5'(MAX_ALINES)) ? 5'(MAX_ALINES) : aline_select;

    // One FIRE step for every channel; a channel is finished once its delay and bits are both spent.
    always_comb begin
        for (int c = 0; c < 8; c++) begin
            dly_adv[c]  = dly_q[c];
            sh_adv[c]   = sh_q[c];
            left_adv[c] = left_q[c];
            if (dly_q[c] != 16'd0) begin
                dly_adv[c] = dly_q[c] - 16'd1;
            end else if (left_q[c] != 6'd0) begin
                sh_adv[c]   = {sh_q[c][30:0], 1'b0};
                left_adv[c] = left_q[c] - 6'd1;
            end
            chan_idle[c] = (dly_adv[c] == 16'd0) && (left_adv[c] == 6'd0);
        end
    end

    assign fire_last = &chan_idle;

    // Next-state and registered-output computation; abort/intaking_configs override everything.
    always_comb begin
        state_d = state_q;
        wa_d    = wa_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rd_en_d = 1'b0;
        fire_d  = 8'h00;
        for (int c = 0; c < 8; c++) begin
            dly_d[c]  = dly_q[c];
            sh_d[c]   = sh_q[c];
            left_d[c] = left_q[c];
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort && !intaking_configs) begin
                    wa_d   = 4'd0;
                    last_d = 4'(n_sel - 5'd1);
                    if (n_sel == 5'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_REQ: begin
                tmo_d   = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI, S_WAIT_LO: begin
                if (tmo_q == TW'(UPD_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (state_q == S_WAIT_HI && updating_delays) begin
                        state_d = S_WAIT_LO;
                    end else if (state_q == S_WAIT_LO && !updating_delays) begin
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                for (int c = 0; c < 8; c++) begin
                    dly_d[c]  = channel_select[c] ? ch_delays[16*c +: 16] : 16'd0;
                    sh_d[c]   = pulse_shape;
                    left_d[c] = channel_select[c] ? 6'd32 : 6'd0;
                end
                state_d = S_FIRE;
            end
            S_FIRE: begin
                for (int c = 0; c < 8; c++) begin
                    dly_d[c]  = dly_adv[c];
                    sh_d[c]   = sh_adv[c];
                    left_d[c] = left_adv[c];
                end
                if (fire_last) begin
                    if (wa_q == last_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    wa_d    = wa_q + 4'd1;
                    state_d = S_REQ;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && (abort || intaking_configs)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = intaking_configs;
            for (int c = 0; c < 8; c++) begin
                left_d[c] = 6'd0;
                dly_d[c]  = 16'd0;
            end
        end

        rd_en_d = (state_d == S_REQ);
        for (int c = 0; c < 8; c++) begin
            fire_d[c] = (state_d == S_FIRE) && (dly_d[c] == 16'd0) &&
                        (left_d[c] != 6'd0) && sh_d[c][31];
        end
    end

    // State and output registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wa_q    <= 4'd0;
            last_q  <= 4'd0;
            tmo_q   <= '0;
            gap_q   <= '0;
            rd_en_q <= 1'b0;
            fire_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int c = 0; c < 8; c++) begin
                dly_q[c]  <= 16'd0;
                sh_q[c]   <= 32'd0;
                left_q[c] <= 6'd0;
            end
        end else begin
            state_q <= state_d;
            wa_q    <= wa_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            rd_en_q <= rd_en_d;
            fire_q  <= fire_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int c = 0; c < 8; c++) begin
                dly_q[c]  <= dly_d[c];
                sh_q[c]   <= sh_d[c];
                left_q[c] <= left_d[c];
            end
        end
    end

    assign rd_en       = rd_en_q;
    assign which_aline = wa_q;
    assign fire        = fire_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_aline_fire_sequencer.sv
// Scoreboard bench: a timeline model predicts every cycle with activity; a monitor pops and compares.
// Latency: predictions are keyed by absolute cycle number.
// Backpressure: an updating_delays responder answers each rd_en after a programmable delay.
module tb_aline_fire_sequencer;

    localparam int GAP = 1000;
    localparam int TMO = 64;
    localparam int K_ABORT  = 0;
    localparam int K_INTAKE = 1;
    localparam int K_RST    = 2;

    logic         clk = 1'b0;
    logic         rst, start, abort, intaking_configs, updating_delays;
    logic [4:0]   aline_select;
    logic [7:0]   channel_select;
    logic [31:0]  pulse_shape;
    logic [127:0] ch_delays;
    logic         rd_en, busy, done, err;
    logic [3:0]   which_aline;
    logic [7:0]   fire;

    aline_fire_sequencer #(.GAP_CYCLES(GAP), .UPD_TIMEOUT(TMO), .MAX_ALINES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .intaking_configs(intaking_configs), .updating_delays(updating_delays),
        .aline_select(aline_select), .channel_select(channel_select),
        .pulse_shape(pulse_shape), .ch_delays(ch_delays),
        .rd_en(rd_en), .which_aline(which_aline), .fire(fire),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       rd;
        logic [3:0] wa;
        logic [7:0] fire;
        logic       done;
        logic       err;
        logic       busy;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic mon_on = 1'b0;
    logic prev_busy = 1'b0;
    int   ud_h = 0;
    int   ud_l = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Responder for the config store: raise updating_delays ud_h cycles after rd_en for ud_l cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_en === 1'b1 && ud_h > 0) begin
                repeat (ud_h) @(posedge clk);
                #1 updating_delays = 1'b1;
                repeat (ud_l) @(posedge clk);
                #1 updating_delays = 1'b0;
            end
        end
    end

    // Monitor: any cycle with rd_en, fire, done, err or a busy change must match the next prediction.
    initial begin
        obs_t act;
        ev_t  ev;
        wait (mon_on);
        forever begin
            @(negedge clk);
            act = {rd_en, which_aline, fire, done, err, busy};
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                ev = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_event: cycle %0d expected %h got nothing", ev.cyc, ev.o);
            end
            if (rd_en || fire != 8'h00 || done || err || busy != prev_busy) begin
                if (exp_q.size() == 0 || exp_q[0].cyc > cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: cycle %0d got %h expected no activity", cyc, act);
                end else begin
                    ev = exp_q.pop_front();
                    chk("event_value", 32'(act), 32'(ev.o));
                end
            end
            prev_busy = busy;
        end
    end

    // Timeline model: one rd_en per A-line, pulse windows at T0+D+k, GAP idle cycles, terminal event.
    task automatic predict(input int s, input int n_req, input logic [7:0] chs, input logic [31:0] shp,
                           input logic [127:0] dl, input int h, input int l,
                           input int stop_at, input int kind, output int end_c);
        obs_t m[int];
        int   dels[$];
        int   starts[16];
        int   n, r, t0, maxd, d, key, f, e, a_cnt, wa;
        obs_t eo;
        n = (n_req > 16) ? 16 : n_req;
        e = s + 1;
        a_cnt = 0;
        if (n == 0) begin
            eo = '0;
            eo.done = 1'b1;
            m[e] = eo;
        end else begin
            r = s + 1;
            for (int a = 0; a < n; a++) begin
                starts[a] = r;
                a_cnt = a + 1;
                eo = '0;
                eo.rd = 1'b1;
                eo.wa = 4'(a);
                eo.busy = 1'b1;
                m[r] = eo;
                if (h <= 0) begin
                    e = r + TMO + 1;
                    eo = '0;
                    eo.err = 1'b1;
                    eo.wa = 4'(a);
                    m[e] = eo;
                    break;
                end
                t0 = r + h + l + 2;
                maxd = -1;
                for (int c = 0; c < 8; c++) begin
                    if (chs[c]) begin
                        d = int'(dl[16*c +: 16]);
                        if (d > maxd) maxd = d;
                        for (int k = 0; k < 32; k++) begin
                            if (shp[31-k]) begin
                                key = t0 + d + k;
                                if (!m.exists(key)) begin
                                    eo = '0;
                                    eo.wa = 4'(a);
                                    eo.busy = 1'b1;
                                    m[key] = eo;
                                end
                                eo = m[key];
                                eo.fire[c] = 1'b1;
                                m[key] = eo;
                            end
                        end
                    end
                end
                f = (maxd < 0) ? t0 : t0 + maxd + 31;
                if (a == n - 1) begin
                    e = f + 1;
                    eo = '0;
                    eo.done = 1'b1;
                    eo.wa = 4'(a);
                    m[e] = eo;
                end else begin
                    r = f + GAP + 1;
                end
            end
        end
        if (stop_at >= 0 && stop_at + 1 <= e) begin
            foreach (m[k]) if (k > stop_at) dels.push_back(k);
            foreach (dels[i]) m.delete(dels[i]);
            wa = 0;
            for (int a = 0; a < a_cnt; a++) if (starts[a] <= stop_at) wa = a;
            eo = '0;
            eo.err = (kind == K_INTAKE);
            eo.wa = (kind == K_RST) ? 4'd0 : 4'(wa);
            e = stop_at + 1;
            m[e] = eo;
        end
        foreach (m[k]) begin
            ev_t ev;
            ev.cyc = k;
            ev.o = m[k];
            exp_q.push_back(ev);
        end
        end_c = e;
    endtask

    // Issue one acquisition; optionally inject abort / intaking_configs / rst stop_rel cycles after start.
    task automatic run(input int n_req, input logic [7:0] chs, input logic [31:0] shp,
                       input logic [127:0] dl, input int h, input int l,
                       input int stop_rel, input int kind, input string nm);
        int s, stop_at, end_c;
        s = cyc;
        stop_at = (stop_rel < 0) ? -1 : s + stop_rel;
        aline_select = 5'(n_req);
        channel_select = chs;
        pulse_shape = shp;
        ch_delays = dl;
        ud_h = h;
        ud_l = l;
        start = 1'b1;
        predict(s, n_req, chs, shp, dl, h, l, stop_at, kind, end_c);
        @(posedge clk);
        #1 start = 1'b0;
        if (stop_at >= 0) begin
            while (cyc < stop_at) begin
                @(posedge clk);
                #1;
            end
            if (kind == K_ABORT) abort = 1'b1;
            else if (kind == K_INTAKE) intaking_configs = 1'b1;
            else rst = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            intaking_configs = 1'b0;
            rst = 1'b0;
        end
        while (cyc < end_c + 3) begin
            @(posedge clk);
            #1;
        end
        chk({nm, "_all_events_seen"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string nm);
        @(negedge clk);
        chk({nm, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({nm, "_which_aline"}, 32'(which_aline), 32'd0);
        chk({nm, "_fire"}, 32'(fire), 32'd0);
        chk({nm, "_busy_done_err"}, 32'({busy, done, err}), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] dl;
        logic [7:0]   chs;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        intaking_configs = 1'b0;
        updating_delays = 1'b0;
        aline_select = 5'd0;
        channel_select = 8'h00;
        pulse_shape = 32'h0;
        ch_delays = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_vals("reset");
        mon_on = 1'b1;

        // Two A-lines, ch0 delay 0, ch1 delay 5, nibble pulse.
        run(2, 8'h03, 32'hF000_0000, 128'h0005_0000, 2, 6, -1, 0, "two_alines");

        // Zero A-lines: done next cycle, no rd_en.
        run(0, 8'h01, 32'hFFFF_FFFF, '0, 2, 2, -1, 0, "zero_alines");

        // No channel enabled: FIRE lasts one cycle.
        run(2, 8'h00, 32'hFFFF_FFFF, '0, 1, 1, -1, 0, "no_channels");

        // Randomized runs.
        for (int i = 0; i < 4; i++) begin
            dl = '0;
            for (int c = 0; c < 8; c++) dl[16*c +: 16] = 16'($urandom_range(0, 40));
            if (i == 3) dl[16*7 +: 16] = 16'h0300;
            chs = 8'($urandom);
            if (i == 3) chs[7] = 1'b1;
            run($urandom_range(1, 3), chs, $urandom, dl,
                $urandom_range(1, 8), $urandom_range(1, 12), -1, 0, "random");
        end

        // A-line count clamp: 20 requested, 16 performed.
        run(20, 8'h10, 32'hA5A5_0001, 128'h3 << 64, 1, 1, -1, 0, "clamp_16");

        // Config store never answers: timeout error.
        run(1, 8'h01, 32'hFFFF_FFFF, '0, 0, 0, -1, 0, "timeout");

        // Abort at T0+2 (T0 = start + 1 + h + l + 2 = start + 8).
        run(2, 8'h0F, 32'hFFF0_0F0F, 128'h0003_0002_0001_0000, 2, 3, 10, K_ABORT, "abort_fire");

        // Reset at the same point.
        run(2, 8'h0F, 32'hFFF0_0F0F, 128'h0003_0002_0001_0000, 2, 3, 10, K_RST, "rst_fire");
        chk_reset_vals("rst_midrun");

        // intaking_configs during GAP (last FIRE = start + 43).
        run(3, 8'h01, 32'h8000_0001, 128'h2, 3, 4, 53, K_INTAKE, "intake_gap");

        // start blocked by intaking_configs, and start with abort in IDLE.
        aline_select = 5'd2;
        channel_select = 8'h01;
        intaking_configs = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 intaking_configs = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("start_blocked_busy", 32'(busy), 32'd0);
        chk("start_blocked_events", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
